// File: rtl/full_adder_unit.sv
// Registered WIDTH-bit ripple-carry adder/subtractor built from 1-bit full-adder cells.
// Define FULL_ADDER_UNIT_FLAGS_EN to generate the ovf/zero flags; otherwise both are tied to 0.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module full_adder_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;

  // mode inverts B and doubles as the carry-in, so subtraction is A + ~B + 1
  assign c[0] = mode;
  assign bb   = b ^ {WIDTH{mode}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (bb[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d    = sum;
      cout_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

`ifdef FULL_ADDER_UNIT_FLAGS_EN
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;

  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (in_valid) begin
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
      zero_d = (sum == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed self-checking bench for full_adder_unit (WIDTH=4), flags expectations follow FULL_ADDER_UNIT_FLAGS_EN.

module tb_full_adder_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       mode = 1'b0;
  logic       out_valid;
  logic [3:0] s;
  logic       cout;
  logic       ovf;
  logic       zero;

  int n_vec = 0;
  int n_err = 0;

  full_adder_unit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic logic fl(input logic x);
`ifdef FULL_ADDER_UNIT_FLAGS_EN
    return x;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [3:0] es,
                         input logic ec, input logic eo, input logic ez);
    chk({tag, ".out_valid"}, {3'b0, out_valid}, {3'b0, ev});
    chk({tag, ".s"}, s, es);
    chk({tag, ".cout"}, {3'b0, cout}, {3'b0, ec});
    chk({tag, ".ovf"}, {3'b0, ovf}, {3'b0, fl(eo)});
    chk({tag, ".zero"}, {3'b0, zero}, {3'b0, fl(ez)});
  endtask

  // Drive on the falling edge, let one rising edge capture, check on the next falling edge.
  task automatic step(input string tag, input logic v, input logic [3:0] ta, input logic [3:0] tb,
                      input logic m, input logic ev, input logic [3:0] es,
                      input logic ec, input logic eo, input logic ez);
    in_valid = v;
    a        = ta;
    b        = tb;
    mode     = m;
    @(posedge clk);
    @(negedge clk);
    chk_all(tag, ev, es, ec, eo, ez);
  endtask

  initial begin
    // Reset held across edges with a live operand on the inputs
    in_valid = 1'b1; a = 4'hF; b = 4'hF; mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all("post_reset_idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Streamed back-to-back: one result per cycle
    step("add_8_2",   1, 4'b1000, 4'b0010, 0, 1, 4'b1010, 0, 0, 0);
    step("sub_8_2",   1, 4'b1000, 4'b0010, 1, 1, 4'b0110, 1, 1, 0);
    step("add_8_8",   1, 4'b1000, 4'b1000, 0, 1, 4'b0000, 1, 1, 1);
    step("sub_8_8",   1, 4'b1000, 4'b1000, 1, 1, 4'b0000, 1, 0, 1);
    step("add_2_8",   1, 4'b0010, 4'b1000, 0, 1, 4'b1010, 0, 0, 0);
    step("sub_2_8",   1, 4'b0010, 4'b1000, 1, 1, 4'b1010, 0, 1, 0);
    step("sub_1_7",   1, 4'b0001, 4'b0111, 1, 1, 4'b1010, 0, 0, 0);
    step("add_a_b",   1, 4'b1010, 4'b1011, 0, 1, 4'b0101, 1, 1, 0);
    step("add_e_f",   1, 4'b1110, 4'b1111, 0, 1, 4'b1101, 1, 0, 0);
    step("sub_e_f",   1, 4'b1110, 4'b1111, 1, 1, 4'b1111, 0, 0, 0);
    step("sub_b_a",   1, 4'b1011, 4'b1010, 1, 1, 4'b0001, 1, 0, 0);

    // Hold: operands change but in_valid is low, so results stay put
    step("hold1", 0, 4'b0111, 4'b0111, 0, 0, 4'b0001, 1, 0, 0);
    step("hold2", 0, 4'b1111, 4'b0001, 0, 0, 4'b0001, 1, 0, 0);
    step("hold3", 0, 4'b1000, 4'b1000, 1, 0, 4'b0001, 1, 0, 0);

    // Flags hold across idle cycles too
    step("add_8_8_again", 1, 4'b1000, 4'b1000, 0, 1, 4'b0000, 1, 1, 1);
    step("hold_flags",    0, 4'b0001, 4'b0001, 0, 0, 4'b0000, 1, 1, 1);

    // Reset mid-operation clears outputs asynchronously and discards the pending result
    in_valid = 1'b1; a = 4'b1010; b = 4'b1011; mode = 1'b0;
    @(posedge clk);
    #2;
    chk_all("pre_async_reset", 1'b1, 4'b0101, 1'b1, 1'b1, 1'b0);
    a = 4'b0011; b = 4'b0100;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all("release_idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step("after_reset", 1, 4'b0011, 4'b0100, 0, 1, 4'b0111, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
